mips_alu: RTL and testbench



---
 rtl/mips_alu_pkg.sv | 10 +
 rtl/mips_alu_datapath.sv | 39 +++
 rtl/mips_alu.sv | 43 ++++
 tb/tb_mips_alu.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: opcode encoding and default width shared by the ALU files.
package mips_alu_pkg;
    localparam int ALU_WIDTH = 32;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;
endpackage

// File: rtl/mips_alu_datapath.sv
// mips_alu_datapath: combinational opcode mux over a shared adder/subtractor.
// Flag generation is built only when MIPS_ALU_FLAGS_EN is defined.
module mips_alu_datapath
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_i,
`ifdef MIPS_ALU_FLAGS_EN
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o,
`endif
    output logic [WIDTH-1:0] res_o
);
    logic             sub;
    logic [WIDTH-1:0] b_x;
    assign sub = sel_i == ALU_SUB;
    assign b_x = sub ? ~b_i : b_i;
`ifdef MIPS_ALU_FLAGS_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
`else
    logic [WIDTH-1:0] sum;
    assign sum = a_i + b_x + {{(WIDTH-1){1'b0}}, sub};
`endif
    always_comb begin
        res_o = (sel_i == ALU_ADD || sel_i == ALU_SUB) ? sum[WIDTH-1:0] :
                (sel_i == ALU_AND) ? (a_i & b_i) : (a_i | b_i);
    end
`ifdef MIPS_ALU_FLAGS_EN
    // With an inverted B and carry-in 1, a clear carry-out means a borrow occurred.
    assign carry_o = ~sel_i[1] & (sum[WIDTH] ^ sub);
    assign ovf_o   = ~sel_i[1] & (a_i[WIDTH-1] == b_x[WIDTH-1]) & (res_o[WIDTH-1] != a_i[WIDTH-1]);
    assign zero_o  = res_o == '0;
`endif
endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit ADD/SUB/AND/OR execute-stage ALU, one-cycle latency.
// Define MIPS_ALU_FLAGS_EN to add registered zero/carry/ovf outputs.
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [1:0]       sel,
`ifdef MIPS_ALU_FLAGS_EN
    output logic             zero,
    output logic             carry,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] out_d, out_q;
`ifdef MIPS_ALU_FLAGS_EN
    logic [2:0] flags_d, flags_q;
    mips_alu_datapath #(.WIDTH(WIDTH)) u_dp (
        .a_i(inputA), .b_i(inputB), .sel_i(sel),
        .zero_o(flags_d[2]), .carry_o(flags_d[1]), .ovf_o(flags_d[0]),
        .res_o(out_d)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else flags_q <= flags_d;
    end
    assign {zero, carry, ovf} = flags_q;
`else
    mips_alu_datapath #(.WIDTH(WIDTH)) u_dp (
        .a_i(inputA), .b_i(inputB), .sel_i(sel), .res_o(out_d)
    );
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else out_q <= out_d;
    end
    assign out = out_q;
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed checks of the registered ALU, including reset and flag cases.
module tb_mips_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inputA = '0, inputB = '0;
    logic [1:0]  sel = '0;
    logic [31:0] out_w;
    int n_assert = 0, n_fail = 0;
`ifdef MIPS_ALU_FLAGS_EN
    logic zero_w, carry_w, ovf_w;
    mips_alu dut (.clk(clk), .rst_n(rst_n), .inputA(inputA), .inputB(inputB), .sel(sel),
                  .zero(zero_w), .carry(carry_w), .ovf(ovf_w), .out(out_w));
`else
    mips_alu dut (.clk(clk), .rst_n(rst_n), .inputA(inputA), .inputB(inputB), .sel(sel),
                  .out(out_w));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        inputA = a;
        inputB = b;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        case (s)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

`ifdef MIPS_ALU_FLAGS_EN
    task automatic chk_flags(input string tag, input logic z, input logic c, input logic v);
        chk({tag, "_zero"}, {31'b0, zero_w}, {31'b0, z});
        chk({tag, "_carry"}, {31'b0, carry_w}, {31'b0, c});
        chk({tag, "_ovf"}, {31'b0, ovf_w}, {31'b0, v});
    endtask
`endif

    initial begin
        logic [31:0] a, b, exp;
        logic [1:0]  s;
        #2;
        chk("reset_out", out_w, 32'd0);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(32'd5001, 32'd3001, 2'd0);
        chk("sweep_add", out_w, 32'd8002);
        step(32'd5001, 32'd3001, 2'd1);
        chk("sweep_sub", out_w, 32'd2000);
        step(32'd5001, 32'd3001, 2'd2);
        chk("sweep_and", out_w, 32'd905);
        step(32'd5001, 32'd3001, 2'd3);
        chk("sweep_or", out_w, 32'd7097);

        step(32'd8006001, 32'd8002, 2'd0);
        chk("add_big", out_w, 32'd8014003);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("add_big", 1'b0, 1'b0, 1'b0);
`endif
        // Operands changing between edges must not disturb the registered result.
        inputA = 32'h1234_5678;
        inputB = 32'h0F0F_0F0F;
        sel = 2'd3;
        #3;
        chk("hold_between_edges", out_w, 32'd8014003);

        step(32'h0000_0000, 32'h0000_0001, 2'd1);
        chk("sub_underflow", out_w, 32'hFFFF_FFFF);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("sub_underflow", 1'b0, 1'b1, 1'b0);
`endif
        step(32'hFFFF_FFFF, 32'h0000_0001, 2'd0);
        chk("add_wrap", out_w, 32'h0000_0000);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("add_wrap", 1'b1, 1'b1, 1'b0);
`endif
        step(32'h7FFF_FFFF, 32'h0000_0001, 2'd0);
        chk("add_ovf", out_w, 32'h8000_0000);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("add_ovf", 1'b0, 1'b0, 1'b1);
`endif
        step(32'h8000_0000, 32'h0000_0001, 2'd1);
        chk("sub_ovf", out_w, 32'h7FFF_FFFF);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("sub_ovf", 1'b0, 1'b0, 1'b1);
`endif
        step(32'hFFFF_0000, 32'h0000_FFFF, 2'd2);
        chk("and_zero", out_w, 32'h0000_0000);
`ifdef MIPS_ALU_FLAGS_EN
        chk_flags("and_zero", 1'b1, 1'b0, 1'b0);
`endif

        step(32'hA5A5_0000, 32'h0000_5A5A, 2'd3);
        chk("pre_reset", out_w, 32'hA5A5_5A5A);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", out_w, 32'd0);
        step(32'd10, 32'd20, 2'd0);
        chk("reset_held_discard", out_w, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("release_no_edge", out_w, 32'd0);
        @(posedge clk);
        #1;
        chk("first_after_release", out_w, 32'd30);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            s = 2'(i);
            exp = model(a, b, s);
            step(a, b, s);
            chk($sformatf("stream_%0d", i), out_w, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
